// File: rtl/code_mem_boot_loader.sv
// Boot sequencer: copies the assembler ROM image into the CPU's writable
// code memory one word at a time and holds the CPU until the copy is complete.
module code_mem_boot_loader #(
  parameter int NUM_WORDS = 32,
  parameter int ADDR_W    = 5,
  parameter int WORD_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  input  logic              imem_ready,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] sum_q;
  logic              accept;
  logic              reload;

  // A write completes only when both sides agree in the same cycle.
  assign accept = (state == WRITE) && imem_ready;
  // start is only honoured when no copy is in flight.
  assign reload = start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
        if (imem_ready) state_nxt = (addr == LAST_ADDR) ? DONE : FETCH;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address, fetched word and running checksum; the write stays frozen
  // while the memory withholds ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      data_q <= '0;
      sum_q  <= '0;
    end else if (reload) begin
      addr  <= '0;
      sum_q <= '0;
    end else begin
      if (state == FETCH) data_q <= rom_data;
      if (accept) begin
        sum_q <= sum_q + data_q;
        if (addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
      end
    end
  end

  assign rom_addr   = addr;
  assign imem_waddr = addr;
  assign imem_wdata = data_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_code_mem_boot_loader.sv
// Directed bench for the code memory boot loader.
module tb_code_mem_boot_loader;

  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        imem_ready;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  logic [15:0] rom [NW];

  int n_chk = 0;
  int n_err = 0;
  int exp_addr;
  int n_wr;
  int n_done;
  logic done_d = 1'b0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  code_mem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .imem_ready (imem_ready),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every accepted write must be the next address in order
  // carrying the ROM word for that address.
  always @(posedge clk) begin
    if (!rst && imem_we && imem_ready) begin
      chk("waddr", 32'(imem_waddr), 32'(exp_addr));
      chk("wdata", 32'(imem_wdata), 32'(rom[imem_waddr]));
      exp_addr++;
      n_wr++;
    end
    if (done && !done_d) n_done++;
    done_d = done;
  end

  task automatic clear_tally();
    exp_addr = 0;
    n_wr     = 0;
    n_done   = 0;
  endtask

  // Pulse start across one edge (edge E) and return the cycle index at which
  // done is first seen high, counting the cycle that ends at edge E+k as k.
  task automatic run_load(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
    lat = 0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; start = 1'b0; imem_ready = 1'b1;
    for (int i = 0; i < NW; i++) rom[i] = 16'h0000;
    rom[0] = 16'h8000; rom[1] = 16'h8401; rom[2] = 16'h1302;
    clear_tally();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    32'(imem_we),  32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd1);
    chk("rst_sum",   32'(checksum), 32'd0);
    chk("rst_raddr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: plain load
    clear_tally();
    run_load(lat);
    chk("t1_lat",  32'(lat),      32'd65);
    chk("t1_nwr",  32'(n_wr),     32'd32);
    chk("t1_sum",  32'(checksum), 32'h1703);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_busy", 32'(busy),     32'd0);

    // 2: three ready-low cycles on word 5
    do_reset();
    clear_tally();
    fork
      run_load(lat);
      begin
        int guard = 0;
        while (!(imem_we && imem_waddr == 5) && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        chk("t2_reach5", 32'(guard < 200), 32'd1);
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("t2_we",    32'(imem_we),    32'd1);
          chk("t2_waddr", 32'(imem_waddr), 32'd5);
          chk("t2_wdata", 32'(imem_wdata), 32'(rom[5]));
        end
        imem_ready = 1'b1;
      end
    join
    chk("t2_lat", 32'(lat),      32'd68);
    chk("t2_nwr", 32'(n_wr),     32'd32);
    chk("t2_sum", 32'(checksum), 32'h1703);

    // 3: start pulses during FETCH and WRITE of word 12 are ignored
    do_reset();
    clear_tally();
    fork
      run_load(lat);
      begin
        int guard = 0;
        while (!(busy && !imem_we && rom_addr == 12) && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        chk("t3_reach12", 32'(guard < 200), 32'd1);
        start = 1'b1;
        @(negedge clk);
        chk("t3_in_write", 32'(imem_we && imem_waddr == 12), 32'd1);
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk("t3_lat",   32'(lat),    32'd65);
    chk("t3_nwr",   32'(n_wr),   32'd32);
    chk("t3_ndone", 32'(n_done), 32'd1);

    // 4: reset while writing word 10, then reload from scratch
    do_reset();
    clear_tally();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int guard = 0;
      while (!(imem_we && imem_waddr == 10) && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      chk("t4_reach10", 32'(guard < 200), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t4_we",   32'(imem_we),  32'd0);
    chk("t4_busy", 32'(busy),     32'd0);
    chk("t4_done", 32'(done),     32'd0);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_sum",  32'(checksum), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_idle_hold", 32'(cpu_hold), 32'd1);
    clear_tally();
    run_load(lat);
    chk("t4_lat", 32'(lat),      32'd65);
    chk("t4_nwr", 32'(n_wr),     32'd32);
    chk("t4_sum2", 32'(checksum), 32'h1703);

    // 5: restart from DONE
    clear_tally();
    run_load(lat);
    chk("t5_lat",  32'(lat),      32'd65);
    chk("t5_nwr",  32'(n_wr),     32'd32);
    chk("t5_sum",  32'(checksum), 32'h1703);
    chk("t5_hold", 32'(cpu_hold), 32'd0);

    // 6: all-ones image wraps the checksum
    for (int i = 0; i < NW; i++) rom[i] = 16'hFFFF;
    clear_tally();
    run_load(lat);
    repeat (4) @(negedge clk);
    chk("t6_lat",  32'(lat),      32'd65);
    chk("t6_nwr",  32'(n_wr),     32'd32);
    chk("t6_sum",  32'(checksum), 32'hFFE0);
    chk("t6_done", 32'(done),     32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
